// File: rtl/blink_seq_ctrl.sv
// blink_seq_ctrl: two-bit LED pattern sequencer on the board clock.
// A synchronous prescaler tick acts as the step enable; no derived clocks.
module blink_seq_ctrl #(
    parameter int CNT_W   = 26,
    parameter int DIV_RST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_ld,
    input  logic [1:0]       mode,
    input  logic             S,
    output logic             tick,
    output logic [1:0]       L
);

    typedef enum logic [1:0] {
        STEP0,
        STEP1,
        STEP2,
        STEP3
    } step_t;

    step_t            state;
    step_t            state_d;
    logic [1:0]       idx_d;
    logic [1:0]       mode_q;
    logic [1:0]       pat_d;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_eff;
    logic [CNT_W-1:0] cnt;
    logic             mode_chg;
    logic             wrap;

    assign mode_chg = mode != mode_q;
    // Divisors of 0 and 1 both mean a tick on every cycle.
    assign div_eff  = (div_q > CNT_W'(1)) ? div_q : CNT_W'(1);
    assign wrap     = cnt == div_eff - CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= STEP0;
            mode_q <= 2'b00;
        end else begin
            state  <= state_d;
            mode_q <= mode;
        end
    end

    always_comb begin
        state_d = state;
        if (mode_chg) begin
            state_d = STEP0;
        end else if (tick && !S) begin
            state_d = step_t'(state + 2'd1);
        end
    end

    assign idx_d = state_d;

    // Decode against the incoming mode so L tracks mode_q and state together.
    always_comb begin
        pat_d = 2'b00;
        unique case (mode)
            2'b00: pat_d = idx_d;
            2'b01: pat_d = idx_d ^ {1'b0, idx_d[1]};
            2'b10: pat_d = idx_d[0] ? 2'b10 : 2'b01;
            2'b11: pat_d = idx_d[0] ? 2'b11 : 2'b00;
            default: pat_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= CNT_W'(DIV_RST);
            cnt   <= '0;
            tick  <= 1'b0;
            L     <= 2'b00;
        end else begin
            L <= S ? 2'b00 : pat_d;
            if (div_ld) begin
                div_q <= div_in;
                cnt   <= '0;
                tick  <= 1'b0;
            end else if (mode_chg) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (S) begin
                tick <= 1'b0;
            end else if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// Bench for blink_seq_ctrl: directed scenarios plus a random phase,
// checked against a pattern-table reference model.
module tb_blink_seq_ctrl;

    localparam int CNT_W   = 26;
    localparam int DIV_RST = 4;

    logic             clk    = 1'b0;
    logic             reset  = 1'b1;
    logic [CNT_W-1:0] div_in = '0;
    logic             div_ld = 1'b0;
    logic [1:0]       mode   = 2'b00;
    logic             S      = 1'b0;
    logic             tick;
    logic [1:0]       L;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: divisor, count, tick, position in pattern, last mode, LEDs.
    int m_div, m_cnt, m_tick, m_pos, m_mq, m_L;
    int seq [4][4] = '{'{0, 1, 2, 3}, '{0, 1, 3, 2},
                       '{1, 2, 1, 2}, '{0, 3, 0, 3}};

    blink_seq_ctrl #(.CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
        .clk   (clk),
        .reset (reset),
        .div_in(div_in),
        .div_ld(div_ld),
        .mode  (mode),
        .S     (S),
        .tick  (tick),
        .L     (L)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_div  = DIV_RST;
        m_cnt  = 0;
        m_tick = 0;
        m_pos  = 0;
        m_mq   = 0;
        m_L    = 0;
    endtask

    task automatic model_edge();
        int eff, nc, nt, np;
        bit chg;
        if (!reset) begin
            mreset();
            return;
        end
        chg = int'(mode) != m_mq;
        eff = (m_div <= 1) ? 1 : m_div;
        np  = m_pos;
        if (chg) np = 0;
        else if (m_tick == 1 && !S) np = (m_pos + 1) % 4;
        nc = m_cnt;
        nt = 0;
        if (div_ld) begin
            m_div = int'(div_in);
            nc = 0;
        end else if (chg) begin
            nc = 0;
        end else if (!S) begin
            if (m_cnt == eff - 1) begin
                nc = 0;
                nt = 1;
            end else begin
                nc = m_cnt + 1;
            end
        end
        m_L    = S ? 0 : seq[int'(mode)][np];
        m_cnt  = nc;
        m_tick = nt;
        m_pos  = np;
        m_mq   = int'(mode);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".tick"}, 32'(tick), 32'(m_tick));
        check({tag, ".L"}, 32'(L), 32'(m_L));
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    // Fresh-from-reset sequence with the reset divisor of 4.
    task automatic s1_seq(input string tag);
        for (int i = 1; i <= 16; i++) begin
            cyc(tag);
            check({tag, ".tickpos"}, 32'(tick), (i % 4 == 0) ? 1 : 0);
            check({tag, ".Lpos"}, 32'(L), ((i - 1) / 4) % 4);
        end
    endtask

    initial begin
        int k;
        mreset();
        #1 reset = 1'b0;
        #11;
        check("rst.tick", 32'(tick), 0);
        check("rst.L", 32'(L), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        s1_seq("s1");

        run("s2pre", 2);
        div_in = 1;
        div_ld = 1'b1;
        cyc("s2ld1");
        check("s2ld1.notick", 32'(tick), 0);
        div_ld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc("s2d1");
            check("s2d1.every", 32'(tick), 1);
        end
        div_in = 0;
        div_ld = 1'b1;
        cyc("s2ld0");
        check("s2ld0.notick", 32'(tick), 0);
        div_ld = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc("s2d0");
            check("s2d0.every", 32'(tick), 1);
        end

        div_in = 4;
        div_ld = 1'b1;
        cyc("s3ld");
        div_ld = 1'b0;
        mode = 2'b01;
        run("s3gray", 34);
        k = 0;
        while (m_tick != 1 && k < 10) begin
            cyc("s3wait");
            k++;
        end
        check("s3.tickfound", 32'(tick), 1);
        mode = 2'b10;
        cyc("s3chg");
        check("s3chg.walk0", 32'(L), 1);
        run("s3walk", 10);

        mode = 2'b00;
        cyc("s4chg");
        k = 0;
        while (m_L != 2 && k < 40) begin
            cyc("s4wait");
            k++;
        end
        check("s4.at10", 32'(L), 2);
        S = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc("s4hold");
            check("s4hold.tick0", 32'(tick), 0);
            check("s4hold.L0", 32'(L), 0);
        end
        S = 1'b0;
        cyc("s4rel");
        check("s4rel.restore", 32'(L), 2);
        run("s4run", 8);

        run("s5pre", 2);
        S = 1'b1;
        div_in = 7;
        div_ld = 1'b1;
        #2 reset = 1'b0;
        #1;
        mreset();
        check("s5async.tick", 32'(tick), 0);
        check("s5async.L", 32'(L), 0);
        run("s5inrst", 2);
        reset = 1'b1;
        S = 1'b0;
        div_ld = 1'b0;
        mode = 2'b00;
        s1_seq("s5seq");

        mode = 2'b11;
        div_in = 3;
        div_ld = 1'b1;
        cyc("s6ld");
        div_ld = 1'b0;
        run("s6blink", 13);
        S = 1'b1;
        run("s6hold", 2);
        mode = 2'b10;
        run("s6holdchg", 3);
        check("s6holdchg.L0", 32'(L), 0);
        S = 1'b0;
        cyc("s6rel");
        check("s6rel.walk0", 32'(L), 1);
        run("s6run", 8);

        for (int i = 0; i < 400; i++) begin
            div_ld = ($urandom_range(0, 19) == 0);
            div_in = CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) S = ~S;
            cyc("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
